// File: rtl/rubik_wr_pkg.sv
// Shared packet layout, mask encodings and FSM states for the rubik write DMA interface.
package rubik_wr_pkg;

    localparam int PKT_W      = 515;
    localparam int PKT_ID_BIT = 514;

    localparam logic PKT_CMD_ID  = 1'b0;
    localparam logic PKT_DATA_ID = 1'b1;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 63;
    localparam int SIZE_LSB = 64;
    localparam int SIZE_MSB = 76;
    localparam int ACK_BIT  = 77;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 511;
    localparam int MASK_LSB = 512;
    localparam int MASK_MSB = 513;

    localparam int ADDR_W     = 64;
    localparam int SIZE_W     = 13;
    localparam int REMAIN_W   = 14;
    localparam int DATA_W     = 512;
    localparam int MASK_W     = 2;
    localparam int CMD_PIPE_W = ADDR_W + SIZE_W + 2;
    localparam int DAT_PIPE_W = MASK_W + DATA_W;

    localparam logic [MASK_W-1:0] MASK_LO   = 2'b01;
    localparam logic [MASK_W-1:0] MASK_BOTH = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } wr_state_e;

endpackage

// File: rtl/rubik_wr_pipe.sv
// One-entry valid/ready register stage; refills in the same cycle the consumer pops.
module rubik_wr_pipe #(
    parameter int W = 8
) (
    input  logic         autosa_core_clk,
    input  logic         autosa_core_rstn,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        in_rdy = !vld_q || out_rdy;
        vld_d  = vld_q;
        data_d = data_q;
        if (in_vld && in_rdy) begin
            vld_d  = 1'b1;
            data_d = in_data;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = data_q;

endmodule

// File: rtl/rubik_wr_dma_if.sv
// Splits the interleaved wr_req stream into memory cmd/data channels, checks beat
// accounting per command and tracks outstanding acked writes for layer completion.
module rubik_wr_dma_if
    import rubik_wr_pkg::*;
#(
    parameter int OST_MAX = 4,
    parameter int OST_W   = 3
) (
    input  logic           autosa_core_clk,
    input  logic           autosa_core_rstn,
    input  logic           wr_req_vld,
    output logic           wr_req_rdy,
    input  logic [514:0]   wr_req_pd,
    input  logic           wr_req_type,
    output logic           dma_wr_cmd_vld,
    input  logic           dma_wr_cmd_rdy,
    output logic [63:0]    dma_wr_cmd_addr,
    output logic [12:0]    dma_wr_cmd_size,
    output logic           dma_wr_cmd_ack,
    output logic           dma_wr_cmd_type,
    output logic           dma_wr_dat_vld,
    input  logic           dma_wr_dat_rdy,
    output logic [511:0]   dma_wr_dat_data,
    output logic [1:0]     dma_wr_dat_mask,
    input  logic           dma_wr_rsp_complete,
    output logic           wr_busy,
    output logic           wr_done,
    output logic           wr_err
);

    wr_state_e             state_q, state_d;
    logic [REMAIN_W-1:0]   remain_q, remain_d;
    logic [REMAIN_W-1:0]   atoms;
    logic [OST_W-1:0]      ost_q, ost_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  cmd_push, dat_push, cmd_loadable, dat_loadable;
    logic                  ost_inc;
    logic [MASK_W-1:0]     pkt_mask, fwd_mask;
    logic [CMD_PIPE_W-1:0] cmd_in, cmd_out;
    logic [DAT_PIPE_W-1:0] dat_in, dat_out;

    assign pkt_mask = wr_req_pd[MASK_MSB:MASK_LSB];

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        err_d      = err_q;
        wr_req_rdy = 1'b0;
        cmd_push   = 1'b0;
        dat_push   = 1'b0;
        atoms      = '0;
        fwd_mask   = pkt_mask;
        case (state_q)
            IDLE: begin
                if (wr_req_pd[PKT_ID_BIT] == PKT_DATA_ID) begin
                    wr_req_rdy = 1'b1;
                    if (wr_req_vld) err_d = 1'b1;
                end else begin
                    wr_req_rdy = cmd_loadable && (ost_q < OST_W'(OST_MAX));
                    if (wr_req_vld && wr_req_rdy) begin
                        cmd_push = 1'b1;
                        remain_d = REMAIN_W'(wr_req_pd[SIZE_MSB:SIZE_LSB]) + REMAIN_W'(1);
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (wr_req_pd[PKT_ID_BIT] == PKT_CMD_ID) begin
                    wr_req_rdy = 1'b1;
                    if (wr_req_vld) err_d = 1'b1;
                end else begin
                    wr_req_rdy = dat_loadable;
                    if (wr_req_vld && wr_req_rdy) begin
                        if (pkt_mask == MASK_BOTH) begin
                            dat_push = 1'b1;
                            if (remain_q == REMAIN_W'(1)) begin
                                // Overrun by one atom: keep the legal half, flag the error.
                                fwd_mask = MASK_LO;
                                atoms    = REMAIN_W'(1);
                                err_d    = 1'b1;
                            end else begin
                                atoms = REMAIN_W'(2);
                            end
                        end else if (pkt_mask == MASK_LO) begin
                            dat_push = 1'b1;
                            atoms    = REMAIN_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                        remain_d = remain_q - atoms;
                        if (remain_d == '0) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ost_inc = dma_wr_cmd_vld && dma_wr_cmd_rdy && dma_wr_cmd_ack;

    always_comb begin
        ost_d  = ost_q;
        done_d = 1'b0;
        if (ost_inc && !dma_wr_rsp_complete) begin
            ost_d = ost_q + OST_W'(1);
        end else if (!ost_inc && dma_wr_rsp_complete) begin
            if (ost_q == '0) begin
                ost_d = '0;
            end else begin
                ost_d  = ost_q - OST_W'(1);
                done_d = (ost_q == OST_W'(1));
            end
        end
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state_q  <= IDLE;
            remain_q <= '0;
            ost_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            ost_q    <= ost_d;
            err_q    <= err_d || (dma_wr_rsp_complete && !ost_inc && (ost_q == '0));
            done_q   <= done_d;
        end
    end

    assign cmd_in = {wr_req_pd[ADDR_MSB:ADDR_LSB], wr_req_pd[SIZE_MSB:SIZE_LSB],
                     wr_req_pd[ACK_BIT], wr_req_type};
    assign dat_in = {fwd_mask, wr_req_pd[DATA_MSB:DATA_LSB]};

    rubik_wr_pipe #(.W(CMD_PIPE_W)) u_cmd_pipe (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .in_vld           (cmd_push),
        .in_rdy           (cmd_loadable),
        .in_data          (cmd_in),
        .out_vld          (dma_wr_cmd_vld),
        .out_rdy          (dma_wr_cmd_rdy),
        .out_data         (cmd_out)
    );

    rubik_wr_pipe #(.W(DAT_PIPE_W)) u_dat_pipe (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .in_vld           (dat_push),
        .in_rdy           (dat_loadable),
        .in_data          (dat_in),
        .out_vld          (dma_wr_dat_vld),
        .out_rdy          (dma_wr_dat_rdy),
        .out_data         (dat_out)
    );

    assign {dma_wr_cmd_addr, dma_wr_cmd_size, dma_wr_cmd_ack, dma_wr_cmd_type} = cmd_out;
    assign {dma_wr_dat_mask, dma_wr_dat_data} = dat_out;

    assign wr_busy = (state_q != IDLE) || (ost_q != '0) || dma_wr_cmd_vld || dma_wr_dat_vld;
    assign wr_done = done_q;
    assign wr_err  = err_q;

endmodule

// File: tb/tb_rubik_wr_dma_if.sv
// Directed bench for rubik_wr_dma_if: expected cmd/data beats are queued at issue
// time and checked by independent channel monitors; status outputs checked inline.
module tb_rubik_wr_dma_if;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         wr_req_vld, wr_req_rdy, wr_req_type;
    logic [514:0] wr_req_pd;
    logic         dma_wr_cmd_vld, dma_wr_cmd_rdy, dma_wr_cmd_ack, dma_wr_cmd_type;
    logic [63:0]  dma_wr_cmd_addr;
    logic [12:0]  dma_wr_cmd_size;
    logic         dma_wr_dat_vld, dma_wr_dat_rdy;
    logic [511:0] dma_wr_dat_data;
    logic [1:0]   dma_wr_dat_mask;
    logic         dma_wr_rsp_complete;
    logic         wr_busy, wr_done, wr_err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [78:0]  exp_cmd_q[$];
    logic [513:0] exp_dat_q[$];
    logic [78:0]  exp_c;
    logic [513:0] exp_d;

    always #5 clk = ~clk;

    rubik_wr_dma_if dut (
        .autosa_core_clk     (clk),
        .autosa_core_rstn    (rstn),
        .wr_req_vld          (wr_req_vld),
        .wr_req_rdy          (wr_req_rdy),
        .wr_req_pd           (wr_req_pd),
        .wr_req_type         (wr_req_type),
        .dma_wr_cmd_vld      (dma_wr_cmd_vld),
        .dma_wr_cmd_rdy      (dma_wr_cmd_rdy),
        .dma_wr_cmd_addr     (dma_wr_cmd_addr),
        .dma_wr_cmd_size     (dma_wr_cmd_size),
        .dma_wr_cmd_ack      (dma_wr_cmd_ack),
        .dma_wr_cmd_type     (dma_wr_cmd_type),
        .dma_wr_dat_vld      (dma_wr_dat_vld),
        .dma_wr_dat_rdy      (dma_wr_dat_rdy),
        .dma_wr_dat_data     (dma_wr_dat_data),
        .dma_wr_dat_mask     (dma_wr_dat_mask),
        .dma_wr_rsp_complete (dma_wr_rsp_complete),
        .wr_busy             (wr_busy),
        .wr_done             (wr_done),
        .wr_err              (wr_err)
    );

    always @(negedge clk) begin
        if (rstn && dma_wr_cmd_vld && dma_wr_cmd_rdy) begin
            n_cmp++;
            if (exp_cmd_q.size() == 0) begin
                n_mis++;
                $display("FAIL cmd_unexpected: got addr=%0h size=%0h", dma_wr_cmd_addr, dma_wr_cmd_size);
            end else begin
                exp_c = exp_cmd_q.pop_front();
                if ({dma_wr_cmd_addr, dma_wr_cmd_size, dma_wr_cmd_ack, dma_wr_cmd_type} !== exp_c) begin
                    n_mis++;
                    $display("FAIL cmd_beat: got %0h expected %0h",
                             {dma_wr_cmd_addr, dma_wr_cmd_size, dma_wr_cmd_ack, dma_wr_cmd_type}, exp_c);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && dma_wr_dat_vld && dma_wr_dat_rdy) begin
            n_cmp++;
            if (exp_dat_q.size() == 0) begin
                n_mis++;
                $display("FAIL dat_unexpected: got mask=%0b data[31:0]=%0h", dma_wr_dat_mask, dma_wr_dat_data[31:0]);
            end else begin
                exp_d = exp_dat_q.pop_front();
                if ({dma_wr_dat_mask, dma_wr_dat_data} !== exp_d) begin
                    n_mis++;
                    $display("FAIL dat_beat: got mask=%0b data[31:0]=%0h expected mask=%0b data[31:0]=%0h",
                             dma_wr_dat_mask, dma_wr_dat_data[31:0], exp_d[513:512], exp_d[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [514:0] mk_cmd(input logic [63:0] a, input logic [12:0] s, input logic ack);
        logic [514:0] p;
        p          = '0;
        p[514]     = 1'b0;
        p[63:0]    = a;
        p[76:64]   = s;
        p[77]      = ack;
        return p;
    endfunction

    function automatic logic [511:0] pat(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic send(input logic [514:0] pd, input logic typ);
        int t;
        t           = 0;
        wr_req_pd   = pd;
        wr_req_type = typ;
        wr_req_vld  = 1'b1;
        @(negedge clk);
        while (!wr_req_rdy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!wr_req_rdy) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_timeout: got rdy=0 expected rdy=1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        wr_req_vld = 1'b0;
    endtask

    task automatic cmd(input logic [63:0] a, input logic [12:0] s, input logic ack, input logic typ);
        exp_cmd_q.push_back({a, s, ack, typ});
        send(mk_cmd(a, s, ack), typ);
    endtask

    task automatic dat(input logic [1:0] mask, input logic [31:0] w, input logic [1:0] exp_mask);
        logic [514:0] p;
        p = {1'b1, mask, pat(w)};
        exp_dat_q.push_back({exp_mask, pat(w)});
        send(p, 1'b0);
    endtask

    task automatic pulse_complete();
        dma_wr_rsp_complete = 1'b1;
        tick(1);
        dma_wr_rsp_complete = 1'b0;
    endtask

    task automatic do_reset();
        check("queues_drained", 64'(exp_cmd_q.size() + exp_dat_q.size()), 64'd0);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    initial begin
        wr_req_vld          = 1'b0;
        wr_req_pd           = '0;
        wr_req_type         = 1'b0;
        dma_wr_cmd_rdy      = 1'b1;
        dma_wr_dat_rdy      = 1'b1;
        dma_wr_rsp_complete = 1'b0;
        tick(2);
        check("rst_cmd_vld", 64'(dma_wr_cmd_vld), 64'd0);
        check("rst_dat_vld", 64'(dma_wr_dat_vld), 64'd0);
        check("rst_done", 64'(wr_done), 64'd0);
        check("rst_err", 64'(wr_err), 64'd0);
        check("rst_busy", 64'(wr_busy), 64'd0);
        check("rst_cmd_addr", dma_wr_cmd_addr, 64'd0);
        check("rst_dat_mask", 64'(dma_wr_dat_mask), 64'd0);
        rstn = 1'b1;
        tick(1);

        // T1: basic 4-atom write with ack, then completion
        cmd(64'h1000, 13'd3, 1'b1, 1'b1);
        check("t1_cmd_latency", 64'(dma_wr_cmd_vld), 64'd1);
        dat(2'b11, 32'h1111_0001, 2'b11);
        dat(2'b11, 32'h1111_0002, 2'b11);
        tick(3);
        check("t1_busy_ost", 64'(wr_busy), 64'd1);
        pulse_complete();
        check("t1_done_pulse", 64'(wr_done), 64'd1);
        tick(1);
        check("t1_done_single", 64'(wr_done), 64'd0);
        check("t1_err", 64'(wr_err), 64'd0);
        check("t1_idle", 64'(wr_busy), 64'd0);

        // T2: 3-atom writes, exact fit then overrun by one atom
        cmd(64'h2000, 13'd2, 1'b0, 1'b0);
        dat(2'b11, 32'h2222_0001, 2'b11);
        dat(2'b01, 32'h2222_0002, 2'b01);
        tick(2);
        check("t2_err_clean", 64'(wr_err), 64'd0);
        cmd(64'h3000, 13'd2, 1'b0, 1'b0);
        dat(2'b11, 32'h3333_0001, 2'b11);
        dat(2'b11, 32'h3333_0002, 2'b01);
        tick(2);
        check("t2_err_overrun", 64'(wr_err), 64'd1);
        check("t2_idle", 64'(wr_busy), 64'd0);
        do_reset();
        check("t2_err_cleared", 64'(wr_err), 64'd0);

        // T3: downstream data stall mid-burst
        cmd(64'h4000, 13'd7, 1'b0, 1'b0);
        dat(2'b11, 32'h4444_0001, 2'b11);
        dma_wr_dat_rdy = 1'b0;
        fork
            begin
                tick(5);
                check("t3_stall_rdy", 64'(wr_req_rdy), 64'd0);
                check("t3_stall_hold", 64'(dma_wr_dat_vld), 64'd1);
                tick(5);
                dma_wr_dat_rdy = 1'b1;
            end
        join_none
        dat(2'b11, 32'h4444_0002, 2'b11);
        dat(2'b11, 32'h4444_0003, 2'b11);
        dat(2'b11, 32'h4444_0004, 2'b11);
        tick(3);
        check("t3_idle", 64'(wr_busy), 64'd0);

        // T4: outstanding limit
        for (int i = 0; i < 4; i++) begin
            cmd(64'h5000 + 64'(i * 64), 13'd0, 1'b1, 1'b0);
            dat(2'b01, 32'h5555_0000 + 32'(i), 2'b01);
        end
        exp_cmd_q.push_back({64'h6000, 13'd0, 1'b1, 1'b1});
        wr_req_pd   = mk_cmd(64'h6000, 13'd0, 1'b1);
        wr_req_type = 1'b1;
        wr_req_vld  = 1'b1;
        tick(3);
        check("t4_held", 64'(wr_req_rdy), 64'd0);
        dma_wr_rsp_complete = 1'b1;
        check("t4_held_at_complete", 64'(wr_req_rdy), 64'd0);
        tick(1);
        dma_wr_rsp_complete = 1'b0;
        check("t4_released", 64'(wr_req_rdy), 64'd1);
        tick(1);
        wr_req_vld = 1'b0;
        dat(2'b01, 32'h6666_0001, 2'b01);
        tick(2);
        do_reset();

        // T5: simultaneous pop and complete, then underflow
        for (int i = 0; i < 2; i++) begin
            cmd(64'h7000 + 64'(i * 64), 13'd0, 1'b1, 1'b0);
            dat(2'b01, 32'h7777_0000 + 32'(i), 2'b01);
        end
        dma_wr_cmd_rdy = 1'b0;
        cmd(64'h7100, 13'd0, 1'b1, 1'b0);
        dat(2'b01, 32'h7777_0002, 2'b01);
        tick(1);
        check("t5_cmd_held", 64'(dma_wr_cmd_vld), 64'd1);
        dma_wr_cmd_rdy      = 1'b1;
        dma_wr_rsp_complete = 1'b1;
        tick(1);
        dma_wr_rsp_complete = 1'b0;
        tick(1);
        pulse_complete();
        check("t5_ost_kept", 64'(wr_done), 64'd0);
        pulse_complete();
        check("t5_done", 64'(wr_done), 64'd1);
        check("t5_err_before", 64'(wr_err), 64'd0);
        tick(1);
        pulse_complete();
        check("t5_no_done_underflow", 64'(wr_done), 64'd0);
        check("t5_err_underflow", 64'(wr_err), 64'd1);
        do_reset();

        // T6: reset in the middle of a burst
        cmd(64'h8000, 13'd6, 1'b1, 1'b1);
        dma_wr_dat_rdy = 1'b0;
        dat(2'b11, 32'h8888_0001, 2'b11);
        tick(2);
        check("t6_pre_busy", 64'(wr_busy), 64'd1);
        check("t6_pre_dat_vld", 64'(dma_wr_dat_vld), 64'd1);
        rstn = 1'b0;
        #1;
        check("t6_rst_cmd_vld", 64'(dma_wr_cmd_vld), 64'd0);
        check("t6_rst_dat_vld", 64'(dma_wr_dat_vld), 64'd0);
        check("t6_rst_busy", 64'(wr_busy), 64'd0);
        exp_dat_q.delete();
        dma_wr_dat_rdy = 1'b1;
        tick(2);
        rstn = 1'b1;
        tick(1);
        cmd(64'h9000, 13'd1, 1'b1, 1'b0);
        dat(2'b11, 32'h9999_0001, 2'b11);
        tick(3);
        pulse_complete();
        check("t6_done", 64'(wr_done), 64'd1);
        check("t6_err", 64'(wr_err), 64'd0);
        tick(2);
        check("t6_idle", 64'(wr_busy), 64'd0);
        check("final_queues", 64'(exp_cmd_q.size() + exp_dat_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
